// File: rtl/signo_excepciones_pipe.sv
`default_nettype none
// ============================================================================
// Module      : signo_excepciones_pipe
// Description : Pipelined multi-lane sign / special-case resolver for an
//               IEEE-754 multiplier. Per lane it XORs the operand signs and
//               classifies the product as NORMAL, ZERO, INF or NAN, flagging
//               invalid operations. Two registered stages, valid/ready on
//               both sides.
//               Optional macro EXC_CNT_EN adds a saturating counter of
//               invalid events (ports Clr_cnt / Cnt_invalido).
// Revision    : 1.0 - initial release
// ============================================================================
module signo_excepciones_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int LANES = 1,
  parameter int CNT_W = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [LANES*(1+EXP_W+MAN_W)-1:0] A,
  input  logic [LANES*(1+EXP_W+MAN_W)-1:0] B,
  input  logic                             In_valid,
  output logic                             In_ready,
  output logic [LANES-1:0]                 Signo,
  output logic [2*LANES-1:0]               Clase,
  output logic [LANES-1:0]                 Invalido,
  output logic                             Out_valid,
`ifdef EXC_CNT_EN
  input  logic                             Clr_cnt,
  output logic [CNT_W-1:0]                 Cnt_invalido,
`endif
  input  logic                             Out_ready
);

  localparam int W = 1 + EXP_W + MAN_W;

  localparam logic [1:0] c_NORMAL = 2'b00;
  localparam logic [1:0] c_ZERO   = 2'b01;
  localparam logic [1:0] c_INF    = 2'b10;
  localparam logic [1:0] c_NAN    = 2'b11;

  // Reject a meaningless counter width at elaboration time.
  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  // Handshake
  logic r_alive;
  logic r_s1_valid;
  logic r_s2_valid;
  logic w_s1_en;
  logic w_s2_en;

  // Operand decode (combinational, from the input ports)
  logic [LANES-1:0] w_a_zero, w_a_inf, w_a_qnan, w_a_snan;
  logic [LANES-1:0] w_b_zero, w_b_inf, w_b_qnan, w_b_snan;
  logic [LANES-1:0] w_sign;

  // Stage 1 registers
  logic [LANES-1:0] r_s1_a_zero, r_s1_a_inf, r_s1_a_qnan, r_s1_a_snan;
  logic [LANES-1:0] r_s1_b_zero, r_s1_b_inf, r_s1_b_qnan, r_s1_b_snan;
  logic [LANES-1:0] r_s1_sign;

  // Stage 2 resolution and registers
  logic [LANES-1:0]   w_res_sign;
  logic [2*LANES-1:0] w_res_cls;
  logic [LANES-1:0]   w_res_inv;
  logic [LANES-1:0]   r_signo;
  logic [2*LANES-1:0] r_cls;
  logic [LANES-1:0]   r_inv;

  // A stage may load when it is empty or when the stage after it drains.
  assign w_s2_en   = ~r_s2_valid | Out_ready;
  assign w_s1_en   = ~r_s1_valid | w_s2_en;
  assign In_ready  = w_s1_en & r_alive;
  assign Out_valid = r_s2_valid;
  assign Signo     = r_signo;
  assign Clase     = r_cls;
  assign Invalido  = r_inv;

  // Per-lane field extraction and operand classification.
  for (genvar i = 0; i < LANES; i++) begin : g_dec
    logic [EXP_W-1:0] w_a_exp, w_b_exp;
    logic [MAN_W-1:0] w_a_frac, w_b_frac;

    assign w_a_exp  = A[i*W+MAN_W +: EXP_W];
    assign w_b_exp  = B[i*W+MAN_W +: EXP_W];
    assign w_a_frac = A[i*W +: MAN_W];
    assign w_b_frac = B[i*W +: MAN_W];

    // exp==0 is ZERO regardless of fraction: denormals flush to zero.
    assign w_a_zero[i] = ~|w_a_exp;
    assign w_a_inf[i]  = (&w_a_exp) & ~|w_a_frac;
    assign w_a_qnan[i] = (&w_a_exp) & w_a_frac[MAN_W-1];
    assign w_a_snan[i] = (&w_a_exp) & ~w_a_frac[MAN_W-1] & (|w_a_frac);

    assign w_b_zero[i] = ~|w_b_exp;
    assign w_b_inf[i]  = (&w_b_exp) & ~|w_b_frac;
    assign w_b_qnan[i] = (&w_b_exp) & w_b_frac[MAN_W-1];
    assign w_b_snan[i] = (&w_b_exp) & ~w_b_frac[MAN_W-1] & (|w_b_frac);

    assign w_sign[i] = A[i*W+W-1] ^ B[i*W+W-1];
  end

  // Input acceptance is held off until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_alive <= 1'b0;
    else        r_alive <= 1'b1;
  end

  // Stage 1: capture operand classes and the raw product sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_a_zero <= '0;
      r_s1_a_inf  <= '0;
      r_s1_a_qnan <= '0;
      r_s1_a_snan <= '0;
      r_s1_b_zero <= '0;
      r_s1_b_inf  <= '0;
      r_s1_b_qnan <= '0;
      r_s1_b_snan <= '0;
      r_s1_sign   <= '0;
    end else if (w_s1_en) begin
      r_s1_valid <= In_valid & r_alive;
      if (In_valid & r_alive) begin
        r_s1_a_zero <= w_a_zero;
        r_s1_a_inf  <= w_a_inf;
        r_s1_a_qnan <= w_a_qnan;
        r_s1_a_snan <= w_a_snan;
        r_s1_b_zero <= w_b_zero;
        r_s1_b_inf  <= w_b_inf;
        r_s1_b_qnan <= w_b_qnan;
        r_s1_b_snan <= w_b_snan;
        r_s1_sign   <= w_sign;
      end
    end
  end

  // Resolve the product class per lane; earlier rules win over later ones.
  always_comb begin
    w_res_sign = '0;
    w_res_cls  = '0;
    w_res_inv  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (r_s1_a_snan[i] | r_s1_b_snan[i]) begin
        w_res_cls[2*i +: 2] = c_NAN;
        w_res_inv[i]        = 1'b1;
      end else if (r_s1_a_qnan[i] | r_s1_b_qnan[i]) begin
        w_res_cls[2*i +: 2] = c_NAN;
      end else if ((r_s1_a_zero[i] & r_s1_b_inf[i]) |
                   (r_s1_a_inf[i] & r_s1_b_zero[i])) begin
        w_res_cls[2*i +: 2] = c_NAN;
        w_res_inv[i]        = 1'b1;
      end else if (r_s1_a_inf[i] | r_s1_b_inf[i]) begin
        w_res_cls[2*i +: 2] = c_INF;
      end else if (r_s1_a_zero[i] | r_s1_b_zero[i]) begin
        w_res_cls[2*i +: 2] = c_ZERO;
      end else begin
        w_res_cls[2*i +: 2] = c_NORMAL;
      end
      // NaN results are always the canonical positive quiet NaN.
      w_res_sign[i] = (w_res_cls[2*i +: 2] == c_NAN) ? 1'b0 : r_s1_sign[i];
    end
  end

  // Stage 2: register the resolved result; holds while stalled downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_signo    <= '0;
      r_cls      <= '0;
      r_inv      <= '0;
    end else if (w_s2_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_signo <= w_res_sign;
        r_cls   <= w_res_cls;
        r_inv   <= w_res_inv;
      end
    end
  end

`ifdef EXC_CNT_EN
  localparam int PC_W  = $clog2(LANES + 1);
  localparam int SUM_W = CNT_W + PC_W;

  logic [PC_W-1:0]  w_pop;
  logic [SUM_W-1:0] w_sum;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_cnt;

  // Number of lanes flagging an invalid operation in the current output.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      w_pop = w_pop + PC_W'(r_inv[i]);
    end
  end

  // The sum is kept one popcount wider so saturation can be detected.
  assign w_sum     = SUM_W'(r_cnt) + SUM_W'(w_pop);
  assign w_cnt_nxt = (w_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}}
                                                     : w_sum[CNT_W-1:0];

  // Saturating invalid-event counter; a clear beats a simultaneous increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_cnt <= '0;
    else if (Clr_cnt)                 r_cnt <= '0;
    else if (r_s2_valid & Out_ready)  r_cnt <= w_cnt_nxt;
  end

  assign Cnt_invalido = r_cnt;
`endif

endmodule
`default_nettype wire
